// File: rtl/ddr_cmd_receiver.sv
// ddr_cmd_receiver
// Host-to-board command parser for the DDR game serial link. It consumes the
// byte stream coming out of the UART receiver and decodes framed packets of
// the form SYNC(0xA5), CMD, LEN, LEN payload bytes, CHK. CHK is the XOR of
// CMD, LEN and every payload byte. An accepted frame updates the game-control
// state (pause, next song, score, arrow status). A rejected frame leaves that
// state untouched and is counted instead.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   rx_data      received byte, meaningful only while rx_valid is high
//   rx_valid     one-cycle strobe per received byte (no backpressure)
//   pause        game pause level (comes out of reset paused)
//   next_song    one-cycle pulse requesting the next song
//   score        16-bit host-supplied score
//   status       32-bit arrow status word, four 8-bit lanes
//   status_valid one-cycle pulse whenever status is rewritten
//   frame_ok     one-cycle pulse per accepted frame
//   frame_err    one-cycle pulse per rejected or aborted frame
//   err_count    number of rejected frames, saturating at 255

module ddr_cmd_receiver #(
  parameter int MAX_PAYLOAD    = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        pause,
  output logic        next_song,
  output logic [15:0] score,
  output logic [31:0] status,
  output logic        status_valid,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam logic [7:0] CMD_SET_PAUSE  = 8'h01;
  localparam logic [7:0] CMD_NEXT_SONG  = 8'h02;
  localparam logic [7:0] CMD_SET_SCORE  = 8'h03;
  localparam logic [7:0] CMD_SET_STATUS = 8'h04;

  localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // The abort fires on the idle cycle whose increment would bring the counter
  // to TIMEOUT_CYCLES-1, so the comparison is against one less than that.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_LEN,
    GET_PAY,
    GET_CHK
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [7:0]         cmd;
  logic [7:0]         len;
  logic [7:0]         chk_acc;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         payload [MAX_PAYLOAD];
  logic [CNT_W-1:0]   tmo_cnt;

  logic               accept;
  logic               reject;
  logic               timeout_hit;
  logic               len_ok;

  // Each command has exactly one legal LEN; anything else (including an
  // unknown opcode) makes the frame unusable even with a good checksum.
  always_comb begin
    len_ok = 1'b0;
    case (cmd)
      CMD_SET_PAUSE:  len_ok = (len == 8'd1);
      CMD_NEXT_SONG:  len_ok = (len == 8'd0);
      CMD_SET_SCORE:  len_ok = (len == 8'd2);
      CMD_SET_STATUS: len_ok = (len == 8'd4);
      default:        len_ok = 1'b0;
    endcase
  end

  // Next-state logic. A byte arriving on the cycle the timeout would fire
  // takes priority, which is why timeout_hit requires rx_valid low.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    reject      = 1'b0;
    timeout_hit = (state != IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

    if (timeout_hit) begin
      state_next = IDLE;
      reject     = 1'b1;
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_next = GET_CMD;
          end
        end
        GET_CMD: begin
          state_next = GET_LEN;
        end
        GET_LEN: begin
          if (rx_data > 8'(MAX_PAYLOAD)) begin
            state_next = IDLE;
            reject     = 1'b1;
          end else if (rx_data == 8'd0) begin
            state_next = GET_CHK;
          end else begin
            state_next = GET_PAY;
          end
        end
        GET_PAY: begin
          if (8'(idx) == (len - 8'd1)) begin
            state_next = GET_CHK;
          end
        end
        GET_CHK: begin
          state_next = IDLE;
          if ((rx_data == chk_acc) && len_ok) begin
            accept = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Inter-byte watchdog: only runs while a frame is open and no byte shows up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if ((state == IDLE) || rx_valid || timeout_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Frame capture: opcode, length, running checksum and payload buffer.
  // LEN is latched even when zero so the length check in GET_CHK sees it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd     <= '0;
      len     <= '0;
      chk_acc <= '0;
      idx     <= '0;
      for (int i = 0; i < MAX_PAYLOAD; i++) begin
        payload[i] <= '0;
      end
    end else if (rx_valid) begin
      case (state)
        GET_CMD: begin
          cmd     <= rx_data;
          chk_acc <= rx_data;
        end
        GET_LEN: begin
          len     <= rx_data;
          chk_acc <= chk_acc ^ rx_data;
          idx     <= '0;
        end
        GET_PAY: begin
          payload[idx] <= rx_data;
          chk_acc      <= chk_acc ^ rx_data;
          idx          <= idx + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Game-control outputs. Pulses default low every cycle so they last
  // exactly one cycle after the CHK (or aborting) edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause        <= 1'b1;
      next_song    <= 1'b0;
      score        <= '0;
      status       <= '0;
      status_valid <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
      err_count    <= '0;
    end else begin
      next_song    <= 1'b0;
      status_valid <= 1'b0;
      frame_ok     <= accept;
      frame_err    <= reject;

      if (accept) begin
        case (cmd)
          CMD_SET_PAUSE:  pause <= payload[0][0];
          CMD_NEXT_SONG:  next_song <= 1'b1;
          CMD_SET_SCORE:  score <= {payload[0], payload[1]};
          CMD_SET_STATUS: begin
            status       <= {payload[0], payload[1], payload[2], payload[3]};
            status_valid <= 1'b1;
          end
          default: begin
          end
        endcase
      end

      if (reject && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_cmd_receiver.sv
// tb_ddr_cmd_receiver
// Directed bench for ddr_cmd_receiver with a short timeout (16 cycles).
// Bytes are driven on the falling edge and outputs are sampled 1 ns after
// the rising edge that consumed the last byte of a step.

module tb_ddr_cmd_receiver;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pause;
  logic        next_song;
  logic [15:0] score;
  logic [31:0] status;
  logic        status_valid;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  ddr_cmd_receiver #(
    .MAX_PAYLOAD(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .pause(pause),
    .next_song(next_song),
    .score(score),
    .status(status),
    .status_valid(status_valid),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_count(err_count)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one byte strobe and returns 1 ns after the edge that consumed it.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Sends n bytes, first byte in the most significant occupied position.
  task automatic send_frame(input logic [8*12-1:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(bytes[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pause, next_song, status_valid, frame_ok, frame_err} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 10000",
               {pause, next_song, status_valid, frame_ok, frame_err});
    end
    checks++;
    if ({score, status, err_count} !== 56'h0) begin
      errors++;
      $display("[TB] FAIL reset_fields: got score=%h status=%h err=%0d expected all zero",
               score, status, err_count);
    end
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();
  endtask

  task automatic test_set_pause();
    send_frame({8'hA5, 8'h01, 8'h01, 8'h00}, 4);
    checks++;
    if (pause !== 1'b1 || frame_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_before_chk: got pause=%b ok=%b expected pause=1 ok=0", pause, frame_ok);
    end
    applyStimulus(8'h00);
    checks++;
    if (pause !== 1'b0 || frame_ok !== 1'b1 || err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL set_pause: got pause=%b ok=%b err=%0d expected 0 1 0", pause, frame_ok, err_count);
    end
    idle_cycle();
    checks++;
    if (frame_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame_ok_width: got %b expected 0", frame_ok);
    end
  endtask

  task automatic test_set_score_status();
    send_frame({8'hA5, 8'h03, 8'h02, 8'h00, 8'h96, 8'h97}, 6);
    checks++;
    if (score !== 16'h0096 || frame_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_score: got score=%h ok=%b expected 0096 1", score, frame_ok);
    end
    send_frame({8'hA5, 8'h04, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}, 8);
    checks++;
    if (status !== 32'h11223344 || status_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_status: got status=%h sv=%b expected 11223344 1", status, status_valid);
    end
    idle_cycle();
    checks++;
    if (status_valid !== 1'b0 || status !== 32'h11223344) begin
      errors++;
      $display("[TB] FAIL status_valid_width: got sv=%b status=%h expected 0 11223344", status_valid, status);
    end
  endtask

  task automatic test_next_song();
    send_frame({8'hA5, 8'h02, 8'h00, 8'h02}, 4);
    checks++;
    if (next_song !== 1'b1) begin
      errors++;
      $display("[TB] FAIL next_song: got %b expected 1", next_song);
    end
    idle_cycle();
    checks++;
    if (next_song !== 1'b0) begin
      errors++;
      $display("[TB] FAIL next_song_width: got %b expected 0", next_song);
    end
    send_frame({8'hA5, 8'h02, 8'h00, 8'h03}, 4);
    checks++;
    if (next_song !== 1'b0 || frame_err !== 1'b1 || frame_ok !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL bad_chk: got ns=%b err=%b ok=%b cnt=%0d expected 0 1 0 1",
               next_song, frame_err, frame_ok, err_count);
    end
  endtask

  task automatic test_garbage_and_len();
    logic seen_err;
    seen_err = 1'b0;
    applyStimulus(8'h00);
    seen_err |= frame_err;
    applyStimulus(8'hFF);
    seen_err |= frame_err;
    applyStimulus(8'h12);
    seen_err |= frame_err;
    checks++;
    if (seen_err !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL garbage: got err_seen=%b cnt=%0d expected 0 1", seen_err, err_count);
    end
    send_frame({8'hA5, 8'h01, 8'h01, 8'h01, 8'h01}, 5);
    checks++;
    if (pause !== 1'b1 || frame_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pause_after_garbage: got pause=%b ok=%b expected 1 1", pause, frame_ok);
    end
    send_frame({8'hA5, 8'h01, 8'h09}, 3);
    checks++;
    if (frame_err !== 1'b1 || err_count !== 8'd2) begin
      errors++;
      $display("[TB] FAIL len_too_big: got err=%b cnt=%0d expected 1 2", frame_err, err_count);
    end
    send_frame({8'hA5, 8'h01, 8'h01, 8'h00, 8'h00}, 5);
    checks++;
    if (pause !== 1'b0 || frame_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_after_len: got pause=%b ok=%b expected 0 1", pause, frame_ok);
    end
  endtask

  task automatic test_bad_cmd_len();
    send_frame({8'hA5, 8'h01, 8'h02, 8'h01, 8'h00, 8'h02}, 6);
    checks++;
    if (frame_err !== 1'b1 || pause !== 1'b0 || err_count !== 8'd3) begin
      errors++;
      $display("[TB] FAIL wrong_len: got err=%b pause=%b cnt=%0d expected 1 0 3", frame_err, pause, err_count);
    end
    send_frame({8'hA5, 8'h07, 8'h00, 8'h07}, 4);
    checks++;
    if (frame_err !== 1'b1 || frame_ok !== 1'b0 || err_count !== 8'd4) begin
      errors++;
      $display("[TB] FAIL unknown_cmd: got err=%b ok=%b cnt=%0d expected 1 0 4", frame_err, frame_ok, err_count);
    end
  endtask

  task automatic test_timeout();
    logic seen_err;
    send_frame({8'hA5, 8'h03}, 2);
    seen_err = 1'b0;
    repeat (14) begin
      idle_cycle();
      seen_err |= frame_err;
    end
    checks++;
    if (seen_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_early: got err_seen=%b expected 0", seen_err);
    end
    idle_cycle();
    checks++;
    if (frame_err !== 1'b1 || err_count !== 8'd5) begin
      errors++;
      $display("[TB] FAIL timeout_fire: got err=%b cnt=%0d expected 1 5", frame_err, err_count);
    end
    send_frame({8'hA5, 8'h03}, 2);
    seen_err = 1'b0;
    repeat (14) begin
      idle_cycle();
      seen_err |= frame_err;
    end
    applyStimulus(8'h02);
    seen_err |= frame_err;
    checks++;
    if (seen_err !== 1'b0 || err_count !== 8'd5) begin
      errors++;
      $display("[TB] FAIL timeout_byte_wins: got err_seen=%b cnt=%0d expected 0 5", seen_err, err_count);
    end
    send_frame({8'h12, 8'h34, 8'h27}, 3);
    checks++;
    if (score !== 16'h1234 || frame_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_continue: got score=%h ok=%b expected 1234 1", score, frame_ok);
    end
  endtask

  task automatic test_back_to_back();
    send_frame({8'hA5, 8'h02, 8'h00, 8'h02}, 4);
    checks++;
    if (next_song !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first: got next_song=%b expected 1", next_song);
    end
    send_frame({8'hA5, 8'h01, 8'h01, 8'h01, 8'h01}, 5);
    checks++;
    if (pause !== 1'b1 || frame_ok !== 1'b1 || next_song !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second: got pause=%b ok=%b ns=%b expected 1 1 0", pause, frame_ok, next_song);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    int bad;
    exp_cnt = 5;
    bad     = 0;
    for (int i = 0; i < 260; i++) begin
      send_frame({8'hA5, 8'h02, 8'h00, 8'h03}, 4);
      if (exp_cnt < 255) exp_cnt++;
      if (err_count !== 8'(exp_cnt) || frame_err !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL saturation_track: got %0d bad frames expected 0", bad);
    end
    checks++;
    if (err_count !== 8'd255 || frame_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL saturation: got cnt=%0d err=%b expected 255 1", err_count, frame_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic seen_err;
    send_frame({8'hA5, 8'h03, 8'h02, 8'h55}, 4);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (score !== 16'h0 || pause !== 1'b1 || err_count !== 8'd0 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got score=%h pause=%b cnt=%0d err=%b expected 0000 1 0 0",
               score, pause, err_count, frame_err);
    end
    @(negedge clk);
    rst = 1'b1;
    seen_err = 1'b0;
    repeat (3) begin
      idle_cycle();
      seen_err |= frame_err;
    end
    send_frame({8'hA5, 8'h03, 8'h02, 8'hAB, 8'hCD, 8'h67}, 6);
    checks++;
    if (seen_err !== 1'b0 || score !== 16'hABCD || frame_ok !== 1'b1 || err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL after_reset: got err_seen=%b score=%h ok=%b cnt=%0d expected 0 abcd 1 0",
               seen_err, score, frame_ok, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_set_pause();
    test_set_score_status();
    test_next_song();
    test_garbage_and_len();
    test_bad_cmd_len();
    test_timeout();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
